// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the PC generator slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [1:0] {
        CAUSE_TRAP   = 2'd0,
        CAUSE_BRANCH = 2'd1,
        CAUSE_JAL    = 2'd2,
        CAUSE_JALR   = 2'd3
    } redirect_cause_t;

    localparam int XLEN_DEFAULT = 32;
    localparam int c_inc_full   = 4;
    localparam int c_inc_comp   = 2;

endpackage

`default_nettype wire

// File: rtl/pc_gen_if.sv
// ============================================================================
// Module      : pc_gen_if
// Description : Request/response bundle between the core and pc_gen.
//               instr_compressed exists only when PC_GEN_RVC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_gen_if #(
    parameter int XLEN = pc_pkg::XLEN_DEFAULT
);
    import pc_pkg::*;

    logic                  stall;
    logic                  pc_ready;
    logic                  redirect_valid;
    redirect_cause_t       redirect_cause;
    logic [XLEN-1:0]       redirect_target;
    logic                  ras_push;
    logic                  ras_pop;
    logic [XLEN-1:0]       ras_push_addr;
`ifdef PC_GEN_RVC_EN
    logic                  instr_compressed;
`endif
    logic [XLEN-1:0]       pc;
    logic                  pc_valid;
    logic [XLEN-1:0]       ras_top;
    logic                  ras_empty;
    logic                  misaligned;
    logic [XLEN-1:0]       misaligned_addr;

    modport master (
`ifdef PC_GEN_RVC_EN
        output instr_compressed,
`endif
        output stall, pc_ready, redirect_valid, redirect_cause, redirect_target,
        output ras_push, ras_pop, ras_push_addr,
        input  pc, pc_valid, ras_top, ras_empty, misaligned, misaligned_addr
    );

    modport slave (
`ifdef PC_GEN_RVC_EN
        input  instr_compressed,
`endif
        input  stall, pc_ready, redirect_valid, redirect_cause, redirect_target,
        input  ras_push, ras_pop, ras_push_addr,
        output pc, pc_valid, ras_top, ras_empty, misaligned, misaligned_addr
    );

endinterface

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack; overflow overwrites the oldest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic            push,
    input  wire logic            pop,
    input  wire logic [XLEN-1:0] push_addr,
    output logic      [XLEN-1:0] top,
    output logic                 empty
);

    localparam int c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(RAS_DEPTH);

    logic [XLEN-1:0]    r_stack [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_ptr_inc;

    assign w_ptr_inc = r_ptr + c_ptr_w'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (push && pop) begin
            r_stack[r_ptr] <= push_addr;
        end else if (push) begin
            // Pointer wraps over the oldest slot once the stack is full.
            r_stack[w_ptr_inc] <= push_addr;
            r_ptr              <= w_ptr_inc;
            if (r_count != c_full) begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end else if (pop && (r_count != '0)) begin
            r_ptr   <= r_ptr - c_ptr_w'(1);
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    assign empty = (r_count == '0);
    assign top   = empty ? '0 : r_stack[r_ptr];

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module      : pc_gen
// Description : Fetch PC generator with redirect, alignment check and RAS.
//               Define PC_GEN_RVC_EN for compressed-instruction support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input wire logic clk,
    input wire logic reset_n,
    pc_gen_if.slave  bus
);

    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic            r_misaligned;
    logic [XLEN-1:0] r_misaligned_addr;

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_inc;
    logic            w_aligned;
    logic            w_advance;

    always_comb begin
        w_target = bus.redirect_target;
        case (bus.redirect_cause)
            CAUSE_TRAP: w_target[1:0] = 2'b00;
            CAUSE_JALR: w_target[0]   = 1'b0;
            default:    ;
        endcase
    end

`ifdef PC_GEN_RVC_EN
    assign w_aligned = ~w_target[0];
    assign w_inc     = bus.instr_compressed ? XLEN'(c_inc_comp) : XLEN'(c_inc_full);
`else
    assign w_aligned = (w_target[1:0] == 2'b00);
    assign w_inc     = XLEN'(c_inc_full);
`endif

    assign w_advance = r_valid && !bus.stall && bus.pc_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc              <= RESET_VECTOR;
            r_valid           <= 1'b0;
            r_misaligned      <= 1'b0;
            r_misaligned_addr <= '0;
        end else begin
            r_valid      <= 1'b1;
            r_misaligned <= 1'b0;
            // A rejected redirect still wins over advance: pc holds.
            if (bus.redirect_valid) begin
                if (w_aligned) begin
                    r_pc <= w_target;
                end else begin
                    r_misaligned      <= 1'b1;
                    r_misaligned_addr <= w_target;
                end
            end else if (w_advance) begin
                r_pc <= r_pc + w_inc;
            end
        end
    end

    assign bus.pc              = r_pc;
    assign bus.pc_valid        = r_valid & ~bus.stall;
    assign bus.misaligned      = r_misaligned;
    assign bus.misaligned_addr = r_misaligned_addr;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.ras_push),
        .pop       (bus.ras_pop),
        .push_addr (bus.ras_push_addr),
        .top       (bus.ras_top),
        .empty     (bus.ras_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module      : tb_pc_gen
// Description : Directed self-checking bench for pc_gen (PC_GEN_RVC_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .RAS_DEPTH    (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall           = 1'b0;
        bus.pc_ready        = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_cause  = CAUSE_TRAP;
        bus.redirect_target = '0;
        bus.ras_push        = 1'b0;
        bus.ras_pop         = 1'b0;
        bus.ras_push_addr   = '0;
`ifdef PC_GEN_RVC_EN
        bus.instr_compressed = 1'b0;
`endif
    endtask

    task automatic redirect(input redirect_cause_t cause, input logic [31:0] target);
        bus.redirect_valid  = 1'b1;
        bus.redirect_cause  = cause;
        bus.redirect_target = target;
        tick();
        bus.redirect_valid  = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [31:0] pop_exp [4] = '{32'h50, 32'h40, 32'h30, 32'h20};
    logic [31:0] push_val [5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        check_eq("rst_pc",        bus.pc, 32'h0);
        check_eq("rst_valid",     bus.pc_valid, 1'b0);
        check_eq("rst_mis",       bus.misaligned, 1'b0);
        check_eq("rst_mis_addr",  bus.misaligned_addr, 32'h0);
        check_eq("rst_ras_empty", bus.ras_empty, 1'b1);
        check_eq("rst_ras_top",   bus.ras_top, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rel_valid0", bus.pc_valid, 1'b0);

        // Sequential fetch after release
        tick(); check_eq("seq_pc0", bus.pc, 32'h0); check_eq("seq_valid", bus.pc_valid, 1'b1);
        tick(); check_eq("seq_pc4", bus.pc, 32'h4);
        tick(); check_eq("seq_pc8", bus.pc, 32'h8);
        tick(); check_eq("seq_pc12", bus.pc, 32'hC);

        // Stall at pc=8 with a JAL redirect
        apply_reset();
        repeat (3) tick();
        check_eq("pre_stall_pc", bus.pc, 32'h8);
        bus.stall = 1'b1;
        #1;
        check_eq("stall_valid", bus.pc_valid, 1'b0);
        redirect(CAUSE_JAL, 32'h100);
        check_eq("jal_stall_pc", bus.pc, 32'h100);
        check_eq("jal_stall_valid", bus.pc_valid, 1'b0);
        repeat (2) tick();
        check_eq("stall_hold_pc", bus.pc, 32'h100);

        // Branch to a half-word target (still stalled)
        redirect(CAUSE_BRANCH, 32'h102);
`ifdef PC_GEN_RVC_EN
        check_eq("br102_pc", bus.pc, 32'h102);
        check_eq("br102_mis", bus.misaligned, 1'b0);
`else
        check_eq("br102_pc", bus.pc, 32'h100);
        check_eq("br102_mis", bus.misaligned, 1'b1);
        check_eq("br102_addr", bus.misaligned_addr, 32'h102);
`endif
        tick();
        check_eq("br102_mis_end", bus.misaligned, 1'b0);

        // JALR drops bit 0 before the alignment check
        redirect(CAUSE_JALR, 32'h203);
`ifdef PC_GEN_RVC_EN
        check_eq("jalr_pc", bus.pc, 32'h202);
        check_eq("jalr_mis", bus.misaligned, 1'b0);
`else
        check_eq("jalr_pc", bus.pc, 32'h100);
        check_eq("jalr_mis", bus.misaligned, 1'b1);
        check_eq("jalr_addr", bus.misaligned_addr, 32'h202);
`endif

        // TRAP forces word alignment
        redirect(CAUSE_TRAP, 32'h307);
        check_eq("trap_pc", bus.pc, 32'h304);
        check_eq("trap_mis", bus.misaligned, 1'b0);

        bus.stall = 1'b0;
        #1;
        check_eq("unstall_valid", bus.pc_valid, 1'b1);
        tick();
        check_eq("unstall_adv", bus.pc, 32'h308);
        bus.pc_ready = 1'b0;
        tick();
        check_eq("notready_hold", bus.pc, 32'h308);
        bus.pc_ready = 1'b1;

        // Wrap at the top of the address space
        redirect(CAUSE_JAL, 32'hFFFF_FFFC);
        check_eq("wrap_pre", bus.pc, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_pc", bus.pc, 32'h0);

`ifdef PC_GEN_RVC_EN
        redirect(CAUSE_JAL, 32'h6);
        bus.instr_compressed = 1'b1;
        check_eq("rvc_pre", bus.pc, 32'h6);
        tick();
        check_eq("rvc_inc2", bus.pc, 32'h8);
        bus.instr_compressed = 1'b0;
`endif

        // RAS overflow and drain
        for (int i = 0; i < 5; i++) begin
            bus.ras_push      = 1'b1;
            bus.ras_push_addr = push_val[i];
            tick();
        end
        bus.ras_push = 1'b0;
        check_eq("ras_full_empty", bus.ras_empty, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("ras_pop%0d_top", i), bus.ras_top, pop_exp[i]);
            bus.ras_pop = 1'b1;
            tick();
            bus.ras_pop = 1'b0;
        end
        check_eq("ras_drained_empty", bus.ras_empty, 1'b1);
        check_eq("ras_drained_top", bus.ras_top, 32'h0);
        bus.ras_pop = 1'b1;
        tick();
        bus.ras_pop = 1'b0;
        check_eq("ras_underflow_empty", bus.ras_empty, 1'b1);
        check_eq("ras_underflow_top", bus.ras_top, 32'h0);

        // Simultaneous push and pop replaces the top
        bus.ras_push = 1'b1; bus.ras_push_addr = 32'hA0; tick();
        bus.ras_push_addr = 32'hB0; tick();
        bus.ras_pop = 1'b1; bus.ras_push_addr = 32'hC0; tick();
        bus.ras_push = 1'b0; bus.ras_pop = 1'b0;
        check_eq("ras_replace_top", bus.ras_top, 32'hC0);
        bus.ras_pop = 1'b1; tick();
        check_eq("ras_after_replace", bus.ras_top, 32'hA0);
        tick();
        bus.ras_pop = 1'b0;
        check_eq("ras_replace_empty", bus.ras_empty, 1'b1);

        // Asynchronous reset mid-cycle drops pending work
        bus.ras_push = 1'b1; bus.ras_push_addr = 32'hD0; tick();
        check_eq("async_pre_ras", bus.ras_empty, 1'b0);
        check_eq("async_pre_pc_nz", (bus.pc != 32'h0), 1'b1);
        bus.ras_push_addr   = 32'hE0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_cause  = CAUSE_JAL;
        bus.redirect_target = 32'h400;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_pc", bus.pc, 32'h0);
        check_eq("async_valid", bus.pc_valid, 1'b0);
        check_eq("async_ras_empty", bus.ras_empty, 1'b1);
        tick();
        check_eq("async_hold_pc", bus.pc, 32'h0);
        check_eq("async_hold_ras", bus.ras_top, 32'h0);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of pc and all address ports.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: pc value held during reset.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of 2, minimum 2.
REQ-004 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port stall, input, 1: hold pc; suppress pc_valid.
REQ-007 Port pc_ready, input, 1: fetch accepts current pc.
REQ-008 Port redirect_valid, input, 1: redirect request this cycle.
REQ-009 Port redirect_cause, input, 2: redirect_cause_t (TRAP=0, BRANCH=1, JAL=2, JALR=3).
REQ-010 Port redirect_target, input, XLEN: redirect destination.
REQ-011 Ports ras_push / ras_pop, input, 1 each: call / return indication.
REQ-012 Port ras_push_addr, input, XLEN: link address to push.
REQ-013 Port pc, output, XLEN: current fetch address.
REQ-014 Port pc_valid, output, 1: pc presentable to fetch.
REQ-015 Ports ras_top, output, XLEN, and ras_empty, output, 1: predicted return address and stack-empty flag.
REQ-016 Ports misaligned, output, 1, and misaligned_addr, output, XLEN: registered one-cycle pulse and offending target.

Function
REQ-017 Handshake: pc_valid SHALL be valid_q AND NOT stall; valid_q is 0 in reset and 1 from the first rising edge after reset release.
REQ-018 Priority per edge: redirect > advance > hold.
REQ-019 Advance: when pc_valid and pc_ready and no redirect, pc SHALL become pc+INC (INC per REQ-027), wrapping modulo 2^XLEN.
REQ-020 Hold: otherwise pc SHALL keep its value.
REQ-021 Redirect SHALL apply on the next edge regardless of stall or pc_ready.
REQ-022 JALR targets SHALL have bit 0 cleared before use; TRAP targets SHALL have bits [1:0] forced to 0.
REQ-023 A non-TRAP target failing the alignment check SHALL leave pc unchanged and, on the next edge, pulse misaligned for one cycle with misaligned_addr = target.
REQ-024 RAS push SHALL write ras_push_addr on top; when full, the oldest entry is overwritten (circular) and the count saturates at RAS_DEPTH.
REQ-025 RAS pop on empty SHALL be ignored; ras_top SHALL read 0 while ras_empty = 1.
REQ-026 Simultaneous push and pop SHALL replace the top entry; count unchanged.

Configuration
REQ-027 With PC_GEN_RVC_EN defined, input port instr_compressed (1 bit) SHALL exist, INC = 2 when instr_compressed = 1, otherwise 4, and the alignment check requires bit 0 = 0; without the macro, the port is absent, INC = 4, and the alignment check requires bits [1:0] = 0.

Reset
REQ-028 While reset_n is low: pc = RESET_VECTOR, pc_valid = 0, misaligned = 0, misaligned_addr = 0, RAS count = 0, ras_empty = 1, ras_top = 0.
REQ-029 Reset assertion mid-operation SHALL discard pending redirect and RAS operations immediately (asynchronously).

Structure
REQ-030 Package pc_pkg SHALL hold redirect_cause_t, XLEN_DEFAULT and the INC constants.
REQ-031 The RAS SHALL be a sub-module pc_ras (parameters XLEN, RAS_DEPTH), instantiated once.

Verification
REQ-032 Reset release, pc_ready = 1, no stall, 4 cycles -> pc sequence 0, 4, 8, 12; pc_valid = 1 from the first edge after release.
REQ-033 stall = 1 at pc = 8 with redirect JAL to 0x100 -> pc_valid = 0 and pc = 0x100 on the next edge; pc stays 0x100 while stalled.
REQ-034 Redirect BRANCH to 0x102 without PC_GEN_RVC_EN -> pc unchanged; misaligned pulses 1 cycle; misaligned_addr = 0x102.
REQ-035 Redirect JALR to 0x203 -> pc = 0x202 with PC_GEN_RVC_EN; misaligned fires (addr 0x202) without it.
REQ-036 RAS_DEPTH = 4: push 0x10, 0x20, 0x30, 0x40, 0x50, then pop 4 times -> ras_top reads 0x50, 0x40, 0x30, 0x20; a fifth pop leaves ras_empty = 1 and ras_top = 0.
REQ-037 pc = 0xFFFF_FFFC, advance -> pc = 0x0000_0000; with PC_GEN_RVC_EN, instr_compressed = 1 and pc = 0x6 -> pc = 0x8.
